// File: rtl/minimicro_ctrl.sv
//==============================================================================
// Module   : minimicro_ctrl
// Brief    : Fetch/decode/execute sequencer for an 8-bit accumulator micro,
//            with conditional jumps, halt, and a fetch-timeout fault.
// Revision : 1.0
//==============================================================================
`default_nettype none

module minimicro_ctrl #(
    parameter int PC_W    = 4,
    parameter int TIMEOUT = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [7:0]      instr,
    input  logic            mem_ready,
    input  logic            n_flag,
    input  logic            z_flag,
    output logic            mem_req,
    output logic [PC_W-1:0] pc,
    output logic [2:0]      alu_op,
    output logic [PC_W-1:0] imm,
    output logic            alu_en,
    output logic            acc_we,
    output logic            sr_we,
    output logic            jump_taken,
    output logic            halted,
    output logic            fault,
    output logic [1:0]      state
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(TIMEOUT - 1);

    localparam logic [3:0] C_OP_LDI = 4'h1;
    localparam logic [3:0] C_OP_OR  = 4'h5;
    localparam logic [3:0] C_OP_JMP = 4'h6;
    localparam logic [3:0] C_OP_JZ  = 4'h7;
    localparam logic [3:0] C_OP_JN  = 4'h8;
    localparam logic [3:0] C_OP_JNZ = 4'h9;
    localparam logic [3:0] C_OP_HLT = 4'hF;

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_DECODE = 2'd1,
        S_EXEC   = 2'd2,
        S_HALT   = 2'd3
    } state_t;

    state_t            r_state;
    logic [PC_W-1:0]   r_pc;
    logic [7:0]        r_ir;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_halted;
    logic              r_fault;

    logic [3:0]        w_opc;
    logic [PC_W-1:0]   w_imm;
    logic              w_in_exec;
    logic              w_is_alu;
    logic              w_take;

    assign w_opc     = r_ir[7:4];
    assign w_in_exec = (r_state == S_EXEC) && !rst;
    assign w_is_alu  = (w_opc >= C_OP_LDI) && (w_opc <= C_OP_OR);

    // The immediate is always the low nibble of the held instruction.
    generate
        if (PC_W == 4) begin : g_imm_eq
            assign w_imm = r_ir[3:0];
        end else if (PC_W > 4) begin : g_imm_ext
            assign w_imm = {{(PC_W-4){1'b0}}, r_ir[3:0]};
        end else begin : g_imm_trunc
            assign w_imm = r_ir[PC_W-1:0];
        end
    endgenerate

    always_comb begin
        w_take = 1'b0;
        case (w_opc)
            C_OP_JMP: w_take = 1'b1;
            C_OP_JZ:  w_take = z_flag;
            C_OP_JN:  w_take = n_flag;
            C_OP_JNZ: w_take = !z_flag;
            default:  w_take = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_FETCH;
            r_pc     <= '0;
            r_ir     <= '0;
            r_cnt    <= '0;
            r_halted <= 1'b0;
            r_fault  <= 1'b0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (mem_ready) begin
                        r_ir    <= instr;
                        r_pc    <= r_pc + PC_W'(1);
                        r_cnt   <= '0;
                        r_state <= S_DECODE;
                    end else if (r_cnt == C_CNT_LAST) begin
                        r_state  <= S_HALT;
                        r_fault  <= 1'b1;
                        r_halted <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_DECODE: begin
                    if (w_opc == C_OP_HLT) begin
                        r_state  <= S_HALT;
                        r_halted <= 1'b1;
                    end else begin
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (w_take) begin
                        r_pc <= w_imm;
                    end
                    r_state <= S_FETCH;
                end
                default: r_state <= S_HALT;
            endcase
        end
    end

    // Strobes decode the registered state and are killed by rst in the same cycle.
    assign mem_req    = (r_state == S_FETCH) && !rst;
    assign alu_en     = w_in_exec && w_is_alu;
    assign acc_we     = w_in_exec && w_is_alu;
    assign sr_we      = w_in_exec && w_is_alu;
    assign jump_taken = w_in_exec && w_take;

    assign pc     = r_pc;
    assign imm    = w_imm;
    assign alu_op = r_ir[6:4];
    assign halted = r_halted;
    assign fault  = r_fault;
    assign state  = r_state;

endmodule

`default_nettype wire
